// File: rtl/lfsr_prbs_checker.sv
// Receive-side checker for an N-bit, M-words-per-beat parallel Fibonacci LFSR stream.
// Seeds its predictor from received data, confirms lock, then flywheels and counts word errors.
module lfsr_prbs_checker #(
    parameter int          LFSR_N     = 8,
    parameter int          LFSR_M     = 4,
    parameter logic [63:0] LFSR_P     = 64'h8E,
    parameter int          LOCK_CNT   = 4,
    parameter int          UNLOCK_CNT = 8,
    parameter int          ERR_CNT_W  = 16
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_chk_enable,
    input  logic                     i_valid,
    input  logic [LFSR_M*LFSR_N-1:0] i_data,
    input  logic                     i_clear,
    output logic                     o_locked,
    output logic [1:0]               o_state,
    output logic                     o_err_valid,
    output logic [LFSR_M-1:0]        o_word_err,
    output logic [ERR_CNT_W-1:0]     o_err_cnt
);

    localparam int GW = $clog2(LOCK_CNT + 1);
    localparam int BW = $clog2(UNLOCK_CNT + 1);
    localparam logic [LFSR_N-1:0] TAPS     = LFSR_P[LFSR_N-1:0];
    localparam logic [GW-1:0]     LOCK_V   = GW'(LOCK_CNT);
    localparam logic [BW-1:0]     UNLOCK_V = BW'(UNLOCK_CNT);

    typedef enum logic [1:0] {
        ST_HUNT   = 2'b00,
        ST_VERIFY = 2'b01,
        ST_LOCKED = 2'b10
    } state_t;

    state_t                 state_q, state_d;
    logic [LFSR_N-1:0]      pred_q, pred_d;
    logic [GW-1:0]          good_q, good_d;
    logic [BW-1:0]          bad_q, bad_d;
    logic [ERR_CNT_W-1:0]   err_cnt_q;
    logic [LFSR_M-1:0]      word_err_q;
    logic                   err_valid_q;

    logic                   accept;
    logic [LFSR_N-1:0]      x;
    logic [LFSR_N-1:0]      exp_w [LFSR_M];
    logic [LFSR_N-1:0]      rx_w  [LFSR_M];
    logic [LFSR_M-1:0]      mism;
    logic [ERR_CNT_W:0]     nerr;
    logic [ERR_CNT_W:0]     sum;
    logic [LFSR_N-1:0]      last_w;

    function automatic logic [LFSR_N-1:0] step(input logic [LFSR_N-1:0] v);
        return {v[LFSR_N-2:0], ^(v & TAPS)};
    endfunction

    assign accept = i_chk_enable & i_valid;

    // Chain of predicted words for this beat, compared against the received words.
    always_comb begin
        x    = pred_q;
        mism = '0;
        nerr = '0;
        for (int j = 0; j < LFSR_M; j++) begin
            x        = step(x);
            exp_w[j] = x;
            rx_w[j]  = i_data[j*LFSR_N +: LFSR_N];
            mism[j]  = (rx_w[j] != exp_w[j]);
            nerr     = nerr + {{ERR_CNT_W{1'b0}}, mism[j]};
        end
        sum    = {1'b0, err_cnt_q} + nerr;
        last_w = rx_w[LFSR_M-1];
    end

    always_comb begin
        state_d = state_q;
        pred_d  = pred_q;
        good_d  = good_q;
        bad_d   = bad_q;
        if (accept) begin
            case (state_q)
                ST_HUNT: begin
                    if (last_w != '0) begin
                        pred_d  = last_w;
                        good_d  = '0;
                        state_d = ST_VERIFY;
                    end
                end
                ST_VERIFY: begin
                    if (mism == '0) begin
                        pred_d = exp_w[LFSR_M-1];
                        if (good_q + GW'(1) == LOCK_V) begin
                            good_d  = '0;
                            bad_d   = '0;
                            state_d = ST_LOCKED;
                        end else begin
                            good_d = good_q + GW'(1);
                        end
                    end else begin
                        good_d = '0;
                        if (last_w == '0) state_d = ST_HUNT;
                        else              pred_d  = last_w;
                    end
                end
                ST_LOCKED: begin
                    // Flywheel: the predictor never reloads from data once locked.
                    pred_d = exp_w[LFSR_M-1];
                    if (mism != '0) begin
                        if (bad_q + BW'(1) == UNLOCK_V) begin
                            bad_d   = '0;
                            state_d = ST_HUNT;
                        end else begin
                            bad_d = bad_q + BW'(1);
                        end
                    end else begin
                        bad_d = '0;
                    end
                end
                default: state_d = ST_HUNT;
            endcase
        end
        if (i_clear) bad_d = '0;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= ST_HUNT;
            pred_q      <= '0;
            good_q      <= '0;
            bad_q       <= '0;
            err_cnt_q   <= '0;
            word_err_q  <= '0;
            err_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pred_q      <= pred_d;
            good_q      <= good_d;
            bad_q       <= bad_d;
            err_valid_q <= accept && (state_q == ST_LOCKED);
            if (accept && (state_q == ST_LOCKED)) word_err_q <= mism;
            else if (state_q != ST_LOCKED)        word_err_q <= '0;
            if (i_clear)
                err_cnt_q <= '0;
            else if (accept && (state_q == ST_LOCKED))
                err_cnt_q <= sum[ERR_CNT_W] ? '1 : sum[ERR_CNT_W-1:0];
        end
    end

    assign o_state     = state_q;
    assign o_locked    = (state_q == ST_LOCKED);
    assign o_err_valid = err_valid_q;
    assign o_word_err  = word_err_q;
    assign o_err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_lfsr_prbs_checker.sv
// Directed bench for lfsr_prbs_checker: lock, flywheel errors, unlock, hunt on zero,
// counter saturation/clear, enable gaps and asynchronous reset.
module tb_lfsr_prbs_checker;

    logic        clk;
    logic        rst_n;
    logic        chk_enable;
    logic        valid;
    logic [31:0] data;
    logic        clear;
    logic        locked;
    logic [1:0]  state;
    logic        err_valid;
    logic [3:0]  word_err;
    logic [15:0] err_cnt;

    int          tests_run = 0;
    int          fails     = 0;
    logic [7:0]  g;
    logic [15:0] exp_cnt;

    lfsr_prbs_checker #(
        .LFSR_N(8), .LFSR_M(4), .LFSR_P(64'h8E),
        .LOCK_CNT(4), .UNLOCK_CNT(8), .ERR_CNT_W(16)
    ) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_chk_enable(chk_enable), .i_valid(valid),
        .i_data(data), .i_clear(clear), .o_locked(locked), .o_state(state),
        .o_err_valid(err_valid), .o_word_err(word_err), .o_err_cnt(err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] step(input logic [7:0] v);
        return {v[6:0], ^(v & 8'h8E)};
    endfunction

    // Drive one beat (continuing generator g), word j bit 0 flipped where mask[j] is set.
    task automatic send(input logic [3:0] mask, input logic clr);
        logic [31:0] b;
        for (int j = 0; j < 4; j++) begin
            g = step(g);
            b[j*8 +: 8] = g ^ (mask[j] ? 8'h01 : 8'h00);
        end
        @(negedge clk);
        data = b; valid = 1'b1; clear = clr;
        @(posedge clk); #1;
        valid = 1'b0; clear = 1'b0;
    endtask

    task automatic send_raw(input logic [31:0] b);
        @(negedge clk);
        data = b; valid = 1'b1;
        @(posedge clk); #1;
        valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            valid = 1'b0;
        end
        @(posedge clk); #1;
    endtask

    task automatic do_reset;
        @(negedge clk);
        rst_n = 1'b0; valid = 1'b0; clear = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset;
        do_reset();
        #1;
        tests_run++; if (state !== 2'b00) begin fails++; $display("FAIL reset_state: got %b want 00", state); end
        tests_run++; if (locked !== 1'b0) begin fails++; $display("FAIL reset_locked: got %b want 0", locked); end
        tests_run++; if (err_cnt !== 16'h0) begin fails++; $display("FAIL reset_cnt: got %h want 0000", err_cnt); end
        tests_run++; if ({err_valid, word_err} !== 5'b0) begin fails++; $display("FAIL reset_err: got %b want 00000", {err_valid, word_err}); end
    endtask

    task automatic test_lock;
        send_raw(32'h341A0D86);
        g = 8'h34;
        tests_run++; if (state !== 2'b01) begin fails++; $display("FAIL lock_verify_b1: got %b want 01", state); end
        for (int b = 2; b <= 4; b++) send(4'b0000, 1'b0);
        tests_run++; if (locked !== 1'b0 || state !== 2'b01) begin fails++; $display("FAIL lock_early_b4: got state %b want 01", state); end
        send(4'b0000, 1'b0);
        tests_run++; if (locked !== 1'b1 || state !== 2'b10) begin fails++; $display("FAIL lock_b5: got state %b locked %b want 10/1", state, locked); end
        tests_run++; if (err_cnt !== 16'h0 || err_valid !== 1'b0) begin fails++; $display("FAIL lock_cnt: got cnt %h ev %b want 0000/0", err_cnt, err_valid); end
    endtask

    task automatic test_single_err;
        send(4'b0100, 1'b0);
        tests_run++; if (err_valid !== 1'b1 || word_err !== 4'b0100) begin fails++; $display("FAIL single_word_err: got ev %b we %b want 1/0100", err_valid, word_err); end
        tests_run++; if (err_cnt !== 16'd1) begin fails++; $display("FAIL single_cnt: got %0d want 1", err_cnt); end
        send(4'b0000, 1'b0);
        tests_run++; if (err_valid !== 1'b1 || word_err !== 4'b0000) begin fails++; $display("FAIL single_flywheel: got ev %b we %b want 1/0000", err_valid, word_err); end
        send(4'b0000, 1'b0);
        tests_run++; if (err_cnt !== 16'd1 || state !== 2'b10) begin fails++; $display("FAIL single_after: got cnt %0d state %b want 1/10", err_cnt, state); end
        idle(1);
        tests_run++; if (err_valid !== 1'b0) begin fails++; $display("FAIL single_pulse: got ev %b want 0", err_valid); end
    endtask

    task automatic test_unlock;
        @(negedge clk); clear = 1'b1;
        @(negedge clk); clear = 1'b0;
        for (int b = 1; b <= 7; b++) send(4'b0001, 1'b0);
        tests_run++; if (state !== 2'b10) begin fails++; $display("FAIL unlock_b7: got %b want 10", state); end
        send(4'b0001, 1'b0);
        tests_run++; if (state !== 2'b00 || locked !== 1'b0) begin fails++; $display("FAIL unlock_b8: got state %b locked %b want 00/0", state, locked); end
        tests_run++; if (err_cnt !== 16'd8) begin fails++; $display("FAIL unlock_cnt: got %0d want 8", err_cnt); end
        for (int b = 1; b <= 5; b++) send(4'b0000, 1'b0);
        tests_run++; if (state !== 2'b10) begin fails++; $display("FAIL relock: got %b want 10", state); end
    endtask

    task automatic test_hunt_zero;
        do_reset();
        send_raw(32'h00112233);
        send_raw(32'h00FFEEDD);
        tests_run++; if (state !== 2'b00) begin fails++; $display("FAIL hunt_zero: got %b want 00", state); end
        send(4'b0000, 1'b0);
        send_raw(32'h00445566);
        tests_run++; if (state !== 2'b00) begin fails++; $display("FAIL verify_zero_to_hunt: got %b want 00", state); end
        send(4'b0000, 1'b0);
        send(4'b0000, 1'b0);
        send(4'b0000, 1'b0);
        send(4'b0010, 1'b0);
        tests_run++; if (state !== 2'b01 || err_valid !== 1'b0) begin fails++; $display("FAIL verify_corrupt: got state %b ev %b want 01/0", state, err_valid); end
        for (int b = 1; b <= 3; b++) send(4'b0000, 1'b0);
        tests_run++; if (state !== 2'b01) begin fails++; $display("FAIL verify_delayed: got %b want 01", state); end
        send(4'b0000, 1'b0);
        tests_run++; if (state !== 2'b10 || err_cnt !== 16'h0) begin fails++; $display("FAIL verify_relock: got state %b cnt %h want 10/0000", state, err_cnt); end
    endtask

    task automatic test_saturate;
        @(negedge clk); clear = 1'b1;
        @(negedge clk); clear = 1'b0;
        exp_cnt = 16'h0;
        for (int grp = 0; grp < 2340; grp++) begin
            for (int b = 0; b < 7; b++) begin send(4'b1111, 1'b0); exp_cnt = exp_cnt + 16'd4; end
            send(4'b0000, 1'b0);
        end
        for (int b = 0; b < 3; b++) begin send(4'b1111, 1'b0); exp_cnt = exp_cnt + 16'd4; end
        send(4'b0011, 1'b0); exp_cnt = exp_cnt + 16'd2;
        send(4'b0000, 1'b0);
        tests_run++; if (err_cnt !== 16'hFFFE || exp_cnt !== 16'hFFFE) begin fails++; $display("FAIL sat_preload: got %h want fffe", err_cnt); end
        send(4'b1111, 1'b0);
        tests_run++; if (err_cnt !== 16'hFFFF) begin fails++; $display("FAIL sat_ffff: got %h want ffff", err_cnt); end
        send(4'b0000, 1'b0);
        send(4'b1111, 1'b1);
        tests_run++; if (err_cnt !== 16'h0) begin fails++; $display("FAIL sat_clear_wins: got %h want 0000", err_cnt); end
        tests_run++; if (err_valid !== 1'b1 || word_err !== 4'b1111 || state !== 2'b10) begin fails++; $display("FAIL sat_clear_err: got ev %b we %b st %b want 1/1111/10", err_valid, word_err, state); end
        send(4'b0000, 1'b0);
    endtask

    task automatic test_gaps;
        idle(3);
        tests_run++; if (state !== 2'b10 || err_valid !== 1'b0) begin fails++; $display("FAIL gap_valid: got st %b ev %b want 10/0", state, err_valid); end
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            chk_enable = 1'b0; valid = 1'b1; data = $urandom_range(32'hFFFF_FFFF, 0);
        end
        @(posedge clk); #1;
        tests_run++; if (state !== 2'b10 || err_valid !== 1'b0 || err_cnt !== 16'h0) begin fails++; $display("FAIL gap_enable: got st %b ev %b cnt %h want 10/0/0000", state, err_valid, err_cnt); end
        @(negedge clk); chk_enable = 1'b1; valid = 1'b0;
        send(4'b0000, 1'b0);
        send(4'b0000, 1'b0);
        tests_run++; if (err_valid !== 1'b1 || word_err !== 4'b0000 || err_cnt !== 16'h0) begin fails++; $display("FAIL gap_resume: got ev %b we %b cnt %h want 1/0000/0000", err_valid, word_err, err_cnt); end
        send(4'b1000, 1'b0);
        tests_run++; if (word_err !== 4'b1000 || err_cnt !== 16'd1) begin fails++; $display("FAIL gap_err: got we %b cnt %0d want 1000/1", word_err, err_cnt); end
        @(negedge clk);
        for (int j = 0; j < 4; j++) begin g = step(g); data[j*8 +: 8] = g ^ 8'h01; end
        valid = 1'b1;
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        tests_run++; if (state !== 2'b00 || locked !== 1'b0) begin fails++; $display("FAIL async_state: got st %b lk %b want 00/0", state, locked); end
        tests_run++; if ({err_valid, word_err} !== 5'b0 || err_cnt !== 16'h0) begin fails++; $display("FAIL async_outputs: got ev/we %b cnt %h want 00000/0000", {err_valid, word_err}, err_cnt); end
        @(negedge clk); valid = 1'b0; rst_n = 1'b1;
        idle(1);
    endtask

    initial begin
        rst_n = 1'b0; chk_enable = 1'b1; valid = 1'b0; data = '0; clear = 1'b0;
        g = 8'hC3;
        test_reset();
        test_lock();
        test_single_err();
        test_unlock();
        test_hunt_zero();
        test_saturate();
        test_gaps();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
